// File: rtl/safe_pkg.sv
// Shared types and defaults for the safe combination-lock core.
package safe_pkg;

   localparam int SAFE_DW       = 6;
   localparam int SAFE_DIAL_MAX = 39;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ENT0 = 3'd1,
      ENT1 = 3'd2,
      ENT2 = 3'd3,
      OPEN = 3'd4,
      FAIL = 3'd5
   } state_t;

endpackage

// File: rtl/safe_combo_lock_if.sv
// Detent strobes, stored combination and display/actuator outputs of the lock core.
interface safe_combo_lock_if #(parameter int DW = 6);
   logic          cnten_n;
   logic          up;
   logic          dirch;
   logic          open_req;
   logic          clr;
   logic [DW-1:0] code0;
   logic [DW-1:0] code1;
   logic [DW-1:0] code2;
   logic [DW-1:0] dial;
   logic [1:0]    digit_idx;
   logic          unlocked;
   logic          error;

   modport master (
      output cnten_n, up, dirch, open_req, clr, code0, code1, code2,
      input  dial, digit_idx, unlocked, error
   );

   modport slave (
      input  cnten_n, up, dirch, open_req, clr, code0, code1, code2,
      output dial, digit_idx, unlocked, error
   );
endinterface

// File: rtl/safe_dial_counter.sv
// Modulo-(DIAL_MAX+1) up/down dial position, one step per active-low strobe.
module safe_dial_counter #(
   parameter int DW       = 6,
   parameter int DIAL_MAX = 39
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cnten_n,
   input  logic          up,
   output logic [DW-1:0] dial
);

   localparam logic [DW-1:0] MAXV = DW'(DIAL_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dial <= '0;
      else if (!cnten_n) begin
         if (up)
            dial <= (dial == MAXV) ? '0 : dial + 1'b1;
         else
            dial <= (dial == '0) ? MAXV : dial - 1'b1;
      end
   end

endmodule

// File: rtl/safe_combo_lock.sv
// Combination-lock core: captures a digit at each dial reversal, then decides
// unlock or timed lockout when the open button is pressed.
module safe_combo_lock
   import safe_pkg::*;
#(
   parameter int DIAL_MAX    = SAFE_DIAL_MAX,
   parameter int DW          = SAFE_DW,
   parameter int OPEN_CYCLES = 8,
   parameter int FAIL_CYCLES = 16
) (
   input logic               clk,
   input logic               rst,
   safe_combo_lock_if.slave  bus
);

   localparam int TMAX = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
   localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

   state_t          state, state_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic            mismatch, mismatch_nxt;
   logic [1:0]      idx_nxt;
   logic [DW-1:0]   dial;
   logic [1:0]      digit_idx;
   logic            unlocked, error;

   safe_dial_counter #(.DW(DW), .DIAL_MAX(DIAL_MAX)) u_dial (
      .clk     (clk),
      .rst     (rst),
      .cnten_n (bus.cnten_n),
      .up      (bus.up),
      .dial    (dial)
   );

   // Comparisons see the pre-count dial, so a reversal coinciding with a
   // detent captures the position the dial was resting on.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      mismatch_nxt = mismatch;
      case (state)
         IDLE: if (!bus.clr && !bus.cnten_n) state_nxt = ENT0;
         ENT0: begin
            if (bus.clr)           state_nxt = IDLE;
            else if (bus.open_req) state_nxt = FAIL;
            else if (bus.dirch) begin
               mismatch_nxt = mismatch | (dial != bus.code0);
               state_nxt    = ENT1;
            end
         end
         ENT1: begin
            if (bus.clr)           state_nxt = IDLE;
            else if (bus.open_req) state_nxt = FAIL;
            else if (bus.dirch) begin
               mismatch_nxt = mismatch | (dial != bus.code1);
               state_nxt    = ENT2;
            end
         end
         ENT2: begin
            if (bus.clr)           state_nxt = IDLE;
            else if (bus.open_req) state_nxt = (!mismatch && dial == bus.code2) ? OPEN : FAIL;
            else if (bus.dirch)    state_nxt = FAIL;
         end
         OPEN: begin
            if (bus.clr || timer == '0) state_nxt = IDLE;
            else                        timer_nxt = timer - 1'b1;
         end
         FAIL: begin
            if (timer == '0) state_nxt = IDLE;
            else             timer_nxt = timer - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == OPEN && state != OPEN) timer_nxt = TW'(OPEN_CYCLES - 1);
      if (state_nxt == FAIL && state != FAIL) timer_nxt = TW'(FAIL_CYCLES - 1);
      if (state_nxt == IDLE) mismatch_nxt = 1'b0;

      case (state_nxt)
         ENT1:    idx_nxt = 2'd1;
         ENT2:    idx_nxt = 2'd2;
         default: idx_nxt = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         mismatch  <= 1'b0;
         digit_idx <= 2'd0;
         unlocked  <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         mismatch  <= mismatch_nxt;
         digit_idx <= idx_nxt;
         unlocked  <= (state_nxt == OPEN);
         error     <= (state_nxt == FAIL);
      end
   end

   assign bus.dial      = dial;
   assign bus.digit_idx = digit_idx;
   assign bus.unlocked  = unlocked;
   assign bus.error     = error;

endmodule
